bg_screen_ctrl: RTL and testbench

Screen sequencer and pixel selector for the three 320x240 background ROMs (menu, level select, result). Decodes keyboard events and the gameplay `game_over` pulse into a four-state screen machine and commits screen changes only at frame boundaries to avoid tearing. Converts 640x480 VGA draw coordinates into ROM addresses and returns one latency-aligned 12-bit background pixel to the colour mapper.

---
 rtl/bg_screen_ctrl_pkg.sv | 21 ++
 rtl/bg_screen_ctrl_if.sv | 33 +++
 rtl/bg_fade_unit.sv | 38 +++
 rtl/bg_screen_ctrl.sv | 126 ++++++++++++
 tb/tb_bg_screen_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/bg_screen_ctrl_pkg.sv
// Shared types and constants for the background screen controller.
package bg_pkg;

   typedef enum logic [1:0] {
      MENU   = 2'd0,
      LEVEL  = 2'd1,
      PLAY   = 2'd2,
      RESULT = 2'd3
   } screen_t;

   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_ESC   = 8'h29;
   localparam logic [7:0] KEY_DOWN  = 8'h51;
   localparam logic [7:0] KEY_UP    = 8'h52;

   localparam int BG_W  = 320;
   localparam int BG_H  = 240;
   localparam int VIS_W = 640;
   localparam int VIS_H = 480;

endpackage

// File: rtl/bg_screen_ctrl_if.sv
// VGA coordinate, event, ROM and pixel signals between the controller and its surroundings.
interface bg_screen_ctrl_if;

   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        frame_start;
   logic        key_valid;
   logic [7:0]  keycode;
   logic        game_over;
   logic [11:0] menu_pic;
   logic [11:0] level_pic;
   logic [11:0] result_pic;
   logic [9:0]  ADDR_X;
   logic [9:0]  ADDR_Y;
   logic [11:0] bg_pixel;
   logic        bg_valid;
   logic [1:0]  screen;
   logic [1:0]  level_sel;
   logic        start_game;

   modport slave (
      input  DrawX, DrawY, frame_start, key_valid, keycode, game_over,
             menu_pic, level_pic, result_pic,
      output ADDR_X, ADDR_Y, bg_pixel, bg_valid, screen, level_sel, start_game
   );

   modport master (
      output DrawX, DrawY, frame_start, key_valid, keycode, game_over,
             menu_pic, level_pic, result_pic,
      input  ADDR_X, ADDR_Y, bg_pixel, bg_valid, screen, level_sel, start_game
   );

endinterface

// File: rtl/bg_fade_unit.sv
// Fade-in ramp: frame counter restarted on each screen change, scaling every RGB444 channel.
module bg_fade_unit #(
   parameter int FADE_FRAMES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        frame_start_i,
   input  logic        restart_i,
   input  logic [11:0] pix_i,
   output logic [11:0] pix_o
);

   localparam logic [3:0] CNT_MAX = 4'(FADE_FRAMES - 1);
   localparam int         SH      = 4 - $clog2(FADE_FRAMES);

   logic [3:0] cnt_q, cnt_d, k;

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i)                              cnt_d = '0;
      else if (frame_start_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   // Saturation forces full scale so the last step is exactly the ROM data.
   assign k = (cnt_q == CNT_MAX) ? 4'hF : 4'(cnt_q << SH);

   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [7:0] prod;
      assign prod = {4'd0, pix_i[c*4 +: 4]} * ({4'd0, k} + 8'd1);
      assign pix_o[c*4 +: 4] = prod[7:4];
   end

endmodule

// File: rtl/bg_screen_ctrl.sv
// Screen sequencer, ROM address mapper and 2-cycle background pixel selector.
// Optional fade-in ramp on screen changes when BG_FADE_EN is defined.
module bg_screen_ctrl
   import bg_pkg::*;
#(
   parameter int FADE_FRAMES = 16
) (
   input  logic            Clk,
   input  logic            Reset_n,
   bg_screen_ctrl_if.slave bus
);

   screen_t    scr_q, scr_d, pend_scr_q, pend_scr_d, req_scr, scr_pipe_q;
   logic       pend_q, pend_d, req, commit;
   logic [1:0] lvl_q, lvl_d;
   logic       start_q, start_d;
   logic       vis, show, is_enter, is_esc;
   logic [1:0] vld_pipe_q;
   logic [11:0] raw, faded, pix_q, pix_d;

   assign is_enter = bus.key_valid && bus.keycode == KEY_ENTER;
   assign is_esc   = bus.key_valid && bus.keycode == KEY_ESC;

   always_comb begin
      req     = 1'b0;
      req_scr = scr_q;
      unique case (scr_q)
         MENU:   if (is_enter) begin req = 1'b1; req_scr = LEVEL; end
         LEVEL:  if (is_enter) begin req = 1'b1; req_scr = PLAY; end
                 else if (is_esc) begin req = 1'b1; req_scr = MENU; end
         PLAY:   if (bus.game_over) begin req = 1'b1; req_scr = RESULT; end
         RESULT: if (is_enter || is_esc) begin req = 1'b1; req_scr = MENU; end
         default: ;
      endcase
   end

   // Only an already-pending request commits; one raised on the frame_start cycle waits a frame.
   assign commit = bus.frame_start && pend_q;

   always_comb begin
      scr_d      = scr_q;
      pend_d     = pend_q;
      pend_scr_d = pend_scr_q;
      lvl_d      = lvl_q;
      start_d    = commit && pend_scr_q == PLAY;
      if (commit) begin
         scr_d  = pend_scr_q;
         pend_d = 1'b0;
         if (pend_scr_q == MENU) lvl_d = '0;
      end else if (req && !pend_q) begin
         pend_d     = 1'b1;
         pend_scr_d = req_scr;
      end
      if (scr_q == LEVEL && !pend_q && bus.key_valid) begin
         if (bus.keycode == KEY_UP && lvl_q != 2'd0)        lvl_d = lvl_q - 2'd1;
         else if (bus.keycode == KEY_DOWN && lvl_q != 2'd2) lvl_d = lvl_q + 2'd1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         scr_q      <= MENU;
         pend_q     <= 1'b0;
         pend_scr_q <= MENU;
         lvl_q      <= '0;
         start_q    <= 1'b0;
      end else begin
         scr_q      <= scr_d;
         pend_q     <= pend_d;
         pend_scr_q <= pend_scr_d;
         lvl_q      <= lvl_d;
         start_q    <= start_d;
      end
   end

   assign vis        = bus.DrawX < 10'(VIS_W) && bus.DrawY < 10'(VIS_H);
   assign bus.ADDR_X = vis ? bus.DrawX / 10'(VIS_W / BG_W) : '0;
   assign bus.ADDR_Y = vis ? bus.DrawY / 10'(VIS_H / BG_H) : '0;

   always_comb begin
      raw = '0;
      unique case (scr_pipe_q)
         MENU:    raw = bus.menu_pic;
         LEVEL:   raw = bus.level_pic;
         RESULT:  raw = bus.result_pic;
         default: raw = '0;
      endcase
   end

   assign show  = vld_pipe_q[0] && scr_pipe_q != PLAY;

`ifdef BG_FADE_EN
   bg_fade_unit #(.FADE_FRAMES(FADE_FRAMES)) u_fade (
      .clk_i        (Clk),
      .rst_ni       (Reset_n),
      .frame_start_i(bus.frame_start),
      .restart_i    (commit),
      .pix_i        (raw),
      .pix_o        (faded)
   );
`else
   assign faded = raw;
`endif

   assign pix_d = show ? faded : '0;

   // Stage 0 lines up screen/visibility with the ROM read, stage 1 is the output register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vld_pipe_q <= '0;
         scr_pipe_q <= MENU;
         pix_q      <= '0;
      end else begin
         vld_pipe_q <= {show, vis};
         scr_pipe_q <= scr_q;
         pix_q      <= pix_d;
      end
   end

   assign bus.bg_pixel   = pix_q;
   assign bus.bg_valid   = vld_pipe_q[1];
   assign bus.screen     = scr_q;
   assign bus.level_sel  = lvl_q;
   assign bus.start_game = start_q;

endmodule

// File: tb/tb_bg_screen_ctrl.sv
// Directed self-checking bench for bg_screen_ctrl (default and BG_FADE_EN builds).
module tb_bg_screen_ctrl;

   logic Clk = 1'b0;
   logic Reset_n;
   int   n_cmp = 0;
   int   n_err = 0;

   bg_screen_ctrl_if bus();

   bg_screen_ctrl #(.FADE_FRAMES(16)) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .bus    (bus)
   );

   always #5 Clk = ~Clk;

`ifdef BG_FADE_EN
   // Fresh commits start the ramp at zero, so every post-commit pixel is black.
   localparam logic [11:0] P_MENU = 12'h000, P_LEVEL = 12'h000, P_RESULT = 12'h000;
   always @(posedge Clk) begin
      bus.menu_pic   <= 12'hFFF;
      bus.level_pic  <= 12'hFFF;
      bus.result_pic <= 12'hFFF;
   end
`else
   // ROM models at DrawX=100, DrawY=50 -> ADDR 50 (0x32), 25 (0x19).
   localparam logic [11:0] P_MENU = 12'h132, P_LEVEL = 12'h219, P_RESULT = 12'h329;
   always @(posedge Clk) begin
      bus.menu_pic   <= {4'h1, bus.ADDR_X[7:0]};
      bus.level_pic  <= {4'h2, bus.ADDR_Y[7:0]};
      bus.result_pic <= {4'h3, bus.ADDR_X[3:0], bus.ADDR_Y[3:0]};
   end
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge Clk);
   endtask

   task automatic key(input logic [7:0] c);
      bus.key_valid = 1'b1;
      bus.keycode   = c;
      tick();
      bus.key_valid = 1'b0;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   initial begin
      Reset_n         = 1'b0;
      bus.DrawX       = 10'd100;
      bus.DrawY       = 10'd50;
      bus.frame_start = 1'b0;
      bus.key_valid   = 1'b0;
      bus.keycode     = 8'h00;
      bus.game_over   = 1'b0;
      tick(2);
      chk("rst_screen", bus.screen, 0);
      chk("rst_level", bus.level_sel, 0);
      chk("rst_start", bus.start_game, 0);
      chk("rst_pixel", bus.bg_pixel, 0);
      chk("rst_valid", bus.bg_valid, 0);
      chk("addr_x", bus.ADDR_X, 50);
      chk("addr_y", bus.ADDR_Y, 25);
      Reset_n = 1'b1;
      tick(2);
      chk("menu_pixel", bus.bg_pixel, P_MENU);
      chk("menu_valid", bus.bg_valid, 1);
      chk("menu_screen", bus.screen, 0);

      key(8'h28);
      tick(10);
      chk("no_frame_hold", bus.screen, 0);
      frame();
      chk("enter_level", bus.screen, 1);
      tick(2);
      chk("level_pixel", bus.bg_pixel, P_LEVEL);

      key(8'h51);
      chk("down1", bus.level_sel, 1);
      key(8'h51); key(8'h51);
      chk("down_sat", bus.level_sel, 2);
      key(8'h52); key(8'h52); key(8'h52);
      chk("up_sat", bus.level_sel, 0);
      key(8'h51);
      chk("down_again", bus.level_sel, 1);

      key(8'h28);
      frame();
      chk("enter_play", bus.screen, 2);
      chk("start_pulse", bus.start_game, 1);
      tick();
      chk("start_end", bus.start_game, 0);
      tick();
      chk("play_valid", bus.bg_valid, 0);
      chk("play_pixel", bus.bg_pixel, 0);

      key(8'h29);
      frame();
      chk("play_key_ign", bus.screen, 2);
      bus.game_over = 1'b1;
      key(8'h28);
      bus.game_over = 1'b0;
      frame();
      chk("enter_result", bus.screen, 3);
      chk("level_held", bus.level_sel, 1);
      tick(2);
      chk("result_pixel", bus.bg_pixel, P_RESULT);
      chk("result_valid", bus.bg_valid, 1);

      key(8'h29);
      frame();
      chk("esc_menu", bus.screen, 0);
      chk("level_clr", bus.level_sel, 0);

      bus.DrawX = 10'd700;
      bus.DrawY = 10'd10;
      tick();
      chk("oob_addr_x", bus.ADDR_X, 0);
      chk("oob_addr_y", bus.ADDR_Y, 0);
      tick(2);
      chk("oob_valid", bus.bg_valid, 0);
      chk("oob_pixel", bus.bg_pixel, 0);

      bus.frame_start = 1'b1;
      key(8'h28);
      bus.frame_start = 1'b0;
      chk("same_cyc_hold", bus.screen, 0);
      frame();
      chk("same_cyc_next", bus.screen, 1);

      key(8'h29);
      key(8'h28);
      frame();
      chk("first_wins", bus.screen, 0);

`ifdef BG_FADE_EN
      bus.DrawX = 10'd100;
      bus.DrawY = 10'd50;
      repeat (7) frame();
      tick(2);
      chk("fade_7", bus.bg_pixel, 12'h777);
      repeat (3) frame();
      tick(2);
      chk("fade_10", bus.bg_pixel, 12'hAAA);
      repeat (8) frame();
      tick(2);
      chk("fade_sat", bus.bg_pixel, 12'hFFF);
      Reset_n = 1'b0;
      tick();
      chk("fade_rst_pix", bus.bg_pixel, 0);
      Reset_n = 1'b1;
      tick(2);
      chk("fade_rst_cnt", bus.bg_pixel, 0);
      chk("fade_rst_vld", bus.bg_valid, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
